// File: rtl/pd_nios2_mul_pkg.sv
// Shared types for the Nios II multiply sequencer: op encoding, FSM states and
// the supported cell-latency ceiling.
package pd_nios2_mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_LO  = 2'd0,
    MUL_OP_HU  = 2'd1,
    MUL_OP_H   = 2'd2,
    MUL_OP_HSU = 2'd3
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam int CELL_LAT_MAX = 4;
  localparam int CNT_W        = 2;

endpackage

// File: rtl/pd_nios2_mul_seq_if.sv
// Request/response channel between the execute-stage issue logic (master)
// and the multiply sequencer (slave).
interface pd_nios2_mul_seq_if;

  // Both channels are valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; the sender holds valid and its payload
  // stable until that edge, and ready may depend on nothing but state.
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/pd_nios2_mul_combine.sv
// Combines the three 16x16 cell products into the 49-bit accumulator and,
// with MULX_EN, the sign-corrected high word.
module pd_nios2_mul_combine
  import pd_nios2_mul_pkg::*;
(
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  input  logic [16:0] acc_hi,
  input  mul_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [48:0] acc_next,
  output logic [31:0] hi_word
);

  logic [32:0] mid_sum;

  // Cross products are summed at 33 bits so their carry lands in acc[48].
  always_comb begin
    mid_sum  = {1'b0, p2} + {1'b0, p3};
    acc_next = {17'd0, p1} + {mid_sum, 16'd0};
  end

`ifdef MULX_EN
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  // Unsigned high word, then subtract the other operand for each operand
  // that is read as negative.
  always_comb begin
    corr_a = '0;
    corr_b = '0;
    if ((op == MUL_OP_H || op == MUL_OP_HSU) && a[31]) corr_b = b;
    if (op == MUL_OP_H && b[31])                       corr_a = a;
    hi_word = {15'd0, acc_hi} + p1 - corr_b - corr_a;
  end
`else
  logic unused_hi_inputs;
  assign unused_hi_inputs = ^{acc_hi, op, a, b};
  assign hi_word          = '0;
`endif

endmodule

// File: rtl/pd_nios2_mul_seq.sv
// Sequences 32x32 multiplies through the three-product 16x16 cell.
// Build option MULX_EN enables MULHU/MULH/MULHSU; without it those ops return rsp_err.
module pd_nios2_mul_seq
  import pd_nios2_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1,
  parameter int DATA_W       = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  pd_nios2_mul_seq_if.slave  bus,
  output logic [31:0]        cell_src1,
  output logic [31:0]        cell_src2,
  output logic               cell_en,
  input  logic [31:0]        cell_p1,
  input  logic [31:0]        cell_p2,
  input  logic [31:0]        cell_p3,
  output state_t             dbg_state
);

`ifdef MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CELL_LATENCY - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mul_op_t            op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [16:0]        acc_hi_q, acc_hi_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [48:0]        acc_next;
  logic [31:0]        hi_word;

  pd_nios2_mul_combine u_combine (
    .p1       (cell_p1),
    .p2       (cell_p2),
    .p3       (cell_p3),
    .acc_hi   (acc_hi_q),
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .acc_next (acc_next),
    .hi_word  (hi_word)
  );

  // Only acc[48:32] survives the low pass; acc[31:0] goes straight to rsp_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MUL_OP_LO;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_hi_d      = acc_hi_q;
    data_d        = data_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    cell_en       = 1'b0;
    cell_src1     = '0;
    cell_src2     = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d  = mul_op_t'(bus.req_op);
          a_d   = bus.req_src1;
          b_d   = bus.req_src2;
          cnt_d = '0;
          if (!MULX && mul_op_t'(bus.req_op) != MUL_OP_LO) begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE_LO;
            err_d   = 1'b0;
          end
        end
      end
      ISSUE_LO: begin
        cell_en   = 1'b1;
        cell_src1 = a_q;
        cell_src2 = b_q;
        state_d   = WAIT_LO;
      end
      // cell_en stays low while waiting, so the cell holds its products.
      WAIT_LO: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d    = '0;
          acc_hi_d = acc_next[48:32];
          if (op_q == MUL_OP_LO || !MULX) begin
            data_d  = acc_next[31:0];
            state_d = RESP;
          end else begin
            state_d = ISSUE_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MULX_EN
      ISSUE_HI: begin
        cell_en   = 1'b1;
        cell_src1 = {16'h0, a_q[31:16]};
        cell_src2 = {16'h0, b_q[31:16]};
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          data_d  = hi_word;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_err  = err_q;
  assign dbg_state    = state_q;

  a_data_w: assert property (@(posedge clk) DATA_W == 32);
  a_cell_lat: assert property (@(posedge clk) CELL_LATENCY >= 1 && CELL_LATENCY <= CELL_LAT_MAX);
  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_err)));

endmodule

// File: doc/pd_nios2_mul_seq.md
Name: pd_nios2_mul_seq

Overview:
Sequencer that runs 32x32 multiply requests through the three-product 16x16 multiplier cell of the Nios II datapath.
- Latches the operands and drives the cell inputs and enable.
- Waits out the cell pipeline, then captures the partial products.
- Combines them into a 32-bit result and returns it over a valid/ready response channel.
- Sits between the execute-stage issue logic and the multiplier cell instance.

Parameters:
CELL_LATENCY, 1, clock edges from cell_en-qualified operands to valid cell_p* outputs (1..4)
DATA_W, 32, operand/result width; fixed at 32, parameter exists for assertions only

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  0=MUL, 1=MULHU, 2=MULH, 3=MULHSU
req_src1  in  32  operand A
req_src2  in  32  operand B
cell_src1  out  32  to cell operand A
cell_src2  out  32  to cell operand B
cell_en  out  1  cell pipeline enable
cell_p1  in  32  cell product A[15:0]*B[15:0]
cell_p2  in  32  cell product A[15:0]*B[31:16]
cell_p3  in  32  cell product A[31:16]*B[15:0]
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  result
rsp_err  out  1  unsupported op

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, cell_en=0, cell_src1/2=0, rsp_valid=0, rsp_data=0, rsp_err=0, accumulator=0.
- States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
- IDLE: req_ready=1. On req_valid, latch op/src1/src2 → ISSUE_LO.
  - If op!=0 and MULX_EN is undefined: go straight to RESP with rsp_err=1, rsp_data=0.
- ISSUE_LO: cell_src1=A, cell_src2=B, cell_en=1 for exactly one cycle → WAIT_LO.
- WAIT_LO: cell_en=0 so the cell holds its outputs. Count CELL_LATENCY-1 cycles, then capture on the last WAIT cycle.
  - acc[48:0] = cell_p1 + ((cell_p2 + cell_p3) << 16), using a 33-bit intermediate sum.
  - op=0 → RESP with rsp_data=acc[31:0]; otherwise → ISSUE_HI.
- ISSUE_HI: cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]}, cell_en=1 → WAIT_HI.
- WAIT_HI: same counting as WAIT_LO. Then compute hi = acc[48:32] + cell_p1 (mod 2^32) → RESP.
- Signed correction, applied mod 2^32:
  - MULH: subtract B if A[31], subtract A if B[31].
  - MULHSU: subtract B if A[31] only.
- RESP: rsp_valid=1. rsp_data/rsp_err stay stable until rsp_ready, then → IDLE.
- req_ready=0 in every state except IDLE. Requests arriving while busy are not accepted (back-pressure only, no drop).
- Latency with CELL_LATENCY=1, request accepted in cycle N:
  - MUL: rsp_valid in N+3.
  - High ops: rsp_valid in N+5.
  - Error: rsp_valid in N+1.
- Minimum issue interval with rsp_ready tied high: 4 cycles (MUL).
- Stall: rsp_ready low holds RESP indefinitely. cell_en stays 0, so the cell contents are preserved.
- Reset mid-operation: the operation is discarded and all outputs return to reset values immediately. No response is produced for it.
- Zero operands and full-scale operands (0xFFFFFFFF) need no special casing. All arithmetic wraps mod 2^32 except acc, which is 49 bits.

Optional Feature:
MULX_EN
- Defined: ops 1-3 run the ISSUE_HI/WAIT_HI pass and return the high word.
- Undefined: ISSUE_HI/WAIT_HI and the correction logic are removed. Ops 1-3 respond with rsp_err=1, rsp_data=0.

Decomposition:
- Package pd_nios2_mul_pkg holds:
  - op enum (MUL_OP_LO, MUL_OP_HU, MUL_OP_H, MUL_OP_HSU);
  - state enum;
  - constant CELL_LAT_MAX=4.
- One sub-module, pd_nios2_mul_combine: purely combinational.
  - Inputs: p1/p2/p3, acc, op, A, B.
  - Outputs: next acc and corrected high word.
  - The FSM and wait counter stay in the top.

Test Plan:
- MUL 0x00012345*0x00000010 with rsp_ready=1 → rsp_data=0x00123450, rsp_err=0, rsp_valid exactly 3 cycles after acceptance.
- MULHU 0xFFFFFFFF*0xFFFFFFFF (MULX_EN) → rsp_data=0xFFFFFFFE; MUL on the same operands → 0x00000001.
- MULH 0x80000000*0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF.
- Without MULX_EN, MULHU 5*7 → rsp_err=1, rsp_data=0, rsp_valid one cycle after acceptance.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_data stable, req_ready=0, cell_en=0 throughout; the next request is accepted only after the handshake.
- Assert reset_n=0 during WAIT_LO → rsp_valid stays 0, state returns to IDLE with req_ready=1 after release, and the following MUL 3*4 returns 12.
